// File: rtl/key_reset_ctrl_pkg.sv
// key_reset_ctrl_pkg: shared FSM state encodings and default debounce/stretch lengths
package key_reset_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    STRETCH = 2'd2
  } state_t;
  localparam int DEB_CYCLES_DEF = 500000;
  localparam int RST_CYCLES_DEF = 16;
endpackage

// File: rtl/key_reset_ctrl_if.sv
// key_reset_ctrl_if: key/reset bundle; key_in to the block, core_rst/key_level/press_pulse/press_count[7:0] back
interface key_reset_ctrl_if;
  logic       key_in;
  logic       core_rst;
  logic       key_level;
  logic       press_pulse;
  logic [7:0] press_count;
  modport master (output key_in, input core_rst, key_level, press_pulse, press_count);
  modport slave (input key_in, output core_rst, key_level, press_pulse, press_count);
endinterface

// File: rtl/key_reset_ctrl_sync_debounce.sv
// sync_debounce: 2-flop sync + 20-bit debounce of key_in; ports clk, rst (async low), key_in -> key_level, level_rise (accepted 0->1 strobe)
module sync_debounce
  import key_reset_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic level_rise
);
  logic        sync1;
  logic        sync2;
  logic [19:0] cnt;
  logic        mismatch;
  logic        hit;
  assign mismatch   = sync2 != key_level;
  assign hit        = mismatch && cnt == 20'(DEB_CYCLES - 1);
  assign level_rise = hit && !key_level;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      cnt       <= '0;
      key_level <= 1'b0;
    end else begin
      sync1     <= key_in;
      sync2     <= sync1;
      cnt       <= (mismatch && !hit) ? cnt + 20'd1 : '0;
      key_level <= key_level ^ hit;
    end
  end
endmodule

// File: rtl/key_reset_ctrl.sv
// key_reset_ctrl: debounced key to stretched core reset; ports clk, rst (async low), bus.slave (key_in in; core_rst, key_level, press_pulse, press_count out)
module key_reset_ctrl
  import key_reset_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF
) (
  input logic           clk,
  input logic           rst,
  key_reset_ctrl_if.slave bus
);
  state_t     state;
  state_t     next_state;
  logic [7:0] scnt;
  logic [7:0] press_count;
  logic       core_rst;
  logic       press_pulse;
  logic       key_level;
  logic       level_rise;
  sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk       (clk),
    .rst       (rst),
    .key_in    (bus.key_in),
    .key_level (key_level),
    .level_rise(level_rise)
  );
  always_comb begin
    next_state = state == HOLD ? (key_level ? HOLD : STRETCH) :
                 level_rise ? HOLD :
                 (state == STRETCH && scnt != 8'(RST_CYCLES - 1)) ? STRETCH : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= STRETCH;
      scnt        <= '0;
      core_rst    <= 1'b1;
      press_pulse <= 1'b0;
      press_count <= '0;
    end else begin
      state       <= next_state;
      scnt        <= (state == STRETCH && next_state == STRETCH) ? scnt + 8'd1 : '0;
      core_rst    <= next_state != IDLE;
      press_pulse <= level_rise;
      press_count <= press_count + 8'(level_rise);
    end
  end
  assign bus.core_rst    = core_rst;
  assign bus.key_level   = key_level;
  assign bus.press_pulse = press_pulse;
  assign bus.press_count = press_count;
endmodule

// File: tb/tb_key_reset_ctrl.sv
// tb_key_reset_ctrl: scoreboard bench for key_reset_ctrl with DEB_CYCLES=4, RST_CYCLES=3
module tb_key_reset_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];
  key_reset_ctrl_if bus ();
  key_reset_ctrl #(.DEB_CYCLES(4), .RST_CYCLES(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic release_check();
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    chk("rel_edge1_core_rst", 32'(bus.core_rst), 1);
    tick();
    chk("rel_edge2_core_rst", 32'(bus.core_rst), 1);
    tick();
    chk("rel_edge3_core_rst", 32'(bus.core_rst), 0);
  endtask
  task automatic press(input int n);
    exp_q.push_back(8'(n));
    bus.key_in = 1'b1;
    repeat (8) tick();
    bus.key_in = 1'b0;
    repeat (12) tick();
  endtask
  always @(negedge clk) begin
    if (rst && bus.press_pulse) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_press_pulse: got count %0d expected no pulse at %0t", bus.press_count, $time);
      end else begin
        chk("pulse_press_count", 32'(bus.press_count), 32'(exp_q.pop_front()));
      end
    end
  end
  initial begin
    bus.key_in = 1'b0;
    #22;
    chk("reset_core_rst", 32'(bus.core_rst), 1);
    chk("reset_key_level", 32'(bus.key_level), 0);
    chk("reset_press_count", 32'(bus.press_count), 0);
    chk("reset_press_pulse", 32'(bus.press_pulse), 0);
    release_check();
    chk("s1_press_count", 32'(bus.press_count), 0);
    bus.key_in = 1'b1;
    repeat (3) tick();
    bus.key_in = 1'b0;
    repeat (8) begin
      tick();
      chk("s2_key_level", 32'(bus.key_level), 0);
      chk("s2_core_rst", 32'(bus.core_rst), 0);
    end
    exp_q.push_back(8'd1);
    bus.key_in = 1'b1;
    repeat (5) tick();
    chk("s3_e5_key_level", 32'(bus.key_level), 0);
    chk("s3_e5_core_rst", 32'(bus.core_rst), 0);
    tick();
    chk("s3_e6_key_level", 32'(bus.key_level), 1);
    chk("s3_e6_press_pulse", 32'(bus.press_pulse), 1);
    chk("s3_e6_press_count", 32'(bus.press_count), 1);
    chk("s3_e6_core_rst", 32'(bus.core_rst), 1);
    tick();
    chk("s3_e7_press_pulse", 32'(bus.press_pulse), 0);
    repeat (13) begin
      tick();
      chk("s3_hold_core_rst", 32'(bus.core_rst), 1);
    end
    bus.key_in = 1'b0;
    repeat (4) tick();
    exp_q.push_back(8'd2);
    bus.key_in = 1'b1;
    repeat (2) begin
      tick();
      chk("s4_fall_core_rst", 32'(bus.core_rst), 1);
    end
    chk("s4_fall_key_level", 32'(bus.key_level), 0);
    repeat (4) begin
      tick();
      chk("s4_stretch_core_rst", 32'(bus.core_rst), 1);
    end
    chk("s4_repress_key_level", 32'(bus.key_level), 1);
    chk("s4_press_count", 32'(bus.press_count), 2);
    repeat (3) begin
      tick();
      chk("s4_hold_core_rst", 32'(bus.core_rst), 1);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("s6_core_rst", 32'(bus.core_rst), 1);
    chk("s6_key_level", 32'(bus.key_level), 0);
    chk("s6_press_count", 32'(bus.press_count), 0);
    chk("s6_press_pulse", 32'(bus.press_pulse), 0);
    bus.key_in = 1'b0;
    release_check();
    for (int n = 1; n <= 256; n++) begin
      press(n);
      if (n == 255) chk("s5_count_255", 32'(bus.press_count), 255);
    end
    chk("s5_count_wrap", 32'(bus.press_count), 0);
    chk("s5_core_rst_idle", 32'(bus.core_rst), 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_reset_ctrl.md
KEY_RESET_CTRL -- requirements
Module: key_reset_ctrl

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 500000, the number of consecutive stable synchronized cycles required to accept a key level change (legal range 1..1048575).
REQ-002 The block SHALL have parameter RST_CYCLES, default 16, the minimum core reset pulse length in cycles after power-on or key release (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port key_in, input, 1 bit: the raw, asynchronous push-button signal (1 = pressed).
REQ-006 The block SHALL have port core_rst, output, 1 bit: the registered active-high reset to the ARM core.
REQ-007 The block SHALL have port key_level, output, 1 bit: the debounced key level.
REQ-008 The block SHALL have port press_pulse, output, 1 bit: a one-cycle strobe on each debounced 0->1 transition.
REQ-009 The block SHALL have port press_count, output, 8 bits: the number of accepted presses, wrapping modulo 256.

Function
REQ-010 key_in SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-011 A 20-bit debounce counter SHALL increment each cycle that sync2 != key_level, and SHALL clear each cycle that sync2 == key_level.
REQ-012 key_level SHALL toggle, and the counter SHALL clear, on the edge where the counter equals DEB_CYCLES-1 with a mismatch present.
REQ-013 A clean input step SHALL appear on key_level exactly DEB_CYCLES+2 rising edges after the first edge that samples the new key_in value.
REQ-014 A key_in pulse shorter than DEB_CYCLES cycles SHALL NOT change key_level.
REQ-015 press_pulse SHALL be 1 for exactly the cycle following a key_level 0->1 change; it SHALL never be asserted for a 1->0 change.
REQ-016 press_count SHALL increment by 1 in the cycle press_pulse is 1, and SHALL wrap from 255 to 0.
REQ-017 The FSM SHALL have three states: IDLE, HOLD and STRETCH, plus an 8-bit stretch counter scnt.
REQ-018 In STRETCH, scnt SHALL increment each cycle; a key_level rise SHALL move the FSM to HOLD; otherwise, when scnt == RST_CYCLES-1 the FSM SHALL move to IDLE with scnt cleared.
REQ-019 In IDLE, a key_level rise SHALL move the FSM to HOLD.
REQ-020 In HOLD, key_level == 0 SHALL move the FSM to STRETCH with scnt = 0.
REQ-021 The core_rst flop SHALL load (next_state != IDLE), so core_rst == 1 exactly while the state register is HOLD or STRETCH.
REQ-022 A re-press during STRETCH SHALL raise press_pulse, increment press_count, and keep core_rst continuously 1 with no gap.

Reset
REQ-023 rst == 0 SHALL immediately force: state = STRETCH, scnt = 0, core_rst = 1, key_level = 0, press_pulse = 0, press_count = 0, sync1 = sync2 = 0, debounce counter = 0.
REQ-024 After rst deasserts with the key released, core_rst SHALL remain 1 for exactly RST_CYCLES clock edges, then fall to 0.
REQ-025 Asserting rst mid-operation (any state) SHALL abort that operation and apply REQ-023 with no further outputs from the aborted operation.

Structure
REQ-026 The state encodings (IDLE = 2'd0, HOLD = 2'd1, STRETCH = 2'd2) and the default DEB_CYCLES and RST_CYCLES values SHALL live in the shared project constants package/include.
REQ-027 The synchronizer and debounce counter (REQ-010 to REQ-014) SHALL be one sub-module, sync_debounce, outputting key_level; the FSM, press logic and counters SHALL stay in key_reset_ctrl.
REQ-028 key_reset_ctrl SHALL replace the existing key-to-reset path in the FPGA wrapper, with core_rst driving the ARM core rst.

Verification (DEB_CYCLES = 4, RST_CYCLES = 3)
REQ-029 Scenario 1: deassert rst, key_in = 0 -> core_rst = 1 for exactly 3 edges then 0; press_count = 0, press_pulse never 1.
REQ-030 Scenario 2: key_in = 1 for 3 cycles, then 0 -> key_level stays 0, no press_pulse, core_rst stays 0.
REQ-031 Scenario 3: key_in = 1 for 20 cycles -> key_level rises 6 edges after the step; press_pulse 1 for one cycle; press_count = 1; core_rst = 1 from that cycle until 3 edges after key_level falls.
REQ-032 Scenario 4: re-press 1 cycle into STRETCH -> FSM returns to HOLD; press_count = 2; core_rst has no 0 cycle.
REQ-033 Scenario 5: 256 clean presses -> press_count reads 255 after the 255th press and 0 after the 256th.
REQ-034 Scenario 6: drop rst during HOLD -> same-cycle (asynchronous) core_rst = 1, key_level = 0, press_count = 0; on release, REQ-024 timing applies.
